// File: rtl/cnn_pkg.sv
// Shared CNN types: default element width, signed data type and the reader FSM states.
package cnn_pkg;

   localparam int unsigned DATA_WIDTH = 16;

   typedef logic signed [DATA_WIDTH-1:0] cnn_data_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      STREAM,
      REPORT
   } reader_state_e;

endpackage

// File: rtl/cnn_result_reader_if.sv
// Result stream and classification report bundle between cnn_result_reader and the host fabric.
interface cnn_result_reader_if #(
   parameter int DATA_WIDTH = 16,
   parameter int IDX_W      = 1
);
   logic signed [DATA_WIDTH-1:0] out_data;
   logic [IDX_W-1:0]             out_index;
   logic                         out_valid;
   logic                         out_ready;
   logic                         out_last;
   logic [IDX_W-1:0]             class_idx;
   logic                         class_valid;

   modport master (
      output out_data, out_index, out_valid, out_last, class_idx, class_valid,
      input  out_ready
   );

   modport slave (
      input  out_data, out_index, out_valid, out_last, class_idx, class_valid,
      output out_ready
   );
endinterface

// File: rtl/cnn_argmax_tracker.sv
// Running signed argmax; first update after clear seeds the maximum, ties keep the lowest index.
module cnn_argmax_tracker
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
   parameter int IDX_W      = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         update,
   input  logic signed [DATA_WIDTH-1:0] data,
   input  logic [IDX_W-1:0]             index,
   output logic signed [DATA_WIDTH-1:0] max_val,
   output logic [IDX_W-1:0]             max_idx
);
   logic                         seen_q;
   logic signed [DATA_WIDTH-1:0] max_val_q;
   logic [IDX_W-1:0]             max_idx_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         seen_q    <= 1'b0;
         max_val_q <= '0;
         max_idx_q <= '0;
      end else if (clear) begin
         seen_q <= 1'b0;
      end else if (update && (!seen_q || data > max_val_q)) begin
         seen_q    <= 1'b1;
         max_val_q <= data;
         max_idx_q <= index;
      end
   end

   assign max_val = max_val_q;
   assign max_idx = max_idx_q;

endmodule

// File: rtl/cnn_result_reader.sv
// Host sequencer: start pulse, wait for done, stream captured FC vector, report argmax.
// Optional wait watchdog enabled by defining CNN_READER_TIMEOUT_EN.
module cnn_result_reader
   import cnn_pkg::*;
#(
   parameter int FC_OUTPUTS     = 2,
   parameter int DATA_WIDTH     = cnn_pkg::DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int IDX_W          = (FC_OUTPUTS > 1) ? $clog2(FC_OUTPUTS) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req,
   output logic                         busy,
   output logic                         cnn_start,
   input  logic                         cnn_done,
   input  logic signed [DATA_WIDTH-1:0] cnn_result [0:FC_OUTPUTS-1],
   output logic                         timeout_err,
   cnn_result_reader_if.master          out_if
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FC_OUTPUTS - 1);

   reader_state_e                state_q;
   logic signed [DATA_WIDTH-1:0] buf_q [0:FC_OUTPUTS-1];
   logic [IDX_W-1:0]             ptr_q;
   logic                         busy_q, start_q, valid_q, last_q, cvalid_q;
   logic [IDX_W-1:0]             cidx_q;
   logic                         accept;
   logic                         trk_clear;
   logic signed [DATA_WIDTH-1:0] unused_trk_max;
   logic [IDX_W-1:0]             trk_idx;

`ifdef CNN_READER_TIMEOUT_EN
   localparam int WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WCNT_W-1:0] wait_cnt_q;
   logic              terr_q;
   assign timeout_err = terr_q;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout_err = 1'b0;
`endif

   assign accept    = valid_q & out_if.out_ready;
   assign trk_clear = (state_q == WAIT) && cnn_done;

   cnn_argmax_tracker #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_argmax (
      .clk     (clk),
      .reset   (reset),
      .clear   (trk_clear),
      .update  (accept),
      .data    (out_if.out_data),
      .index   (ptr_q),
      .max_val (unused_trk_max),
      .max_idx (trk_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         busy_q   <= 1'b0;
         start_q  <= 1'b0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         cvalid_q <= 1'b0;
         cidx_q   <= '0;
         for (int unsigned i = 0; i < FC_OUTPUTS; i++) buf_q[i] <= '0;
`ifdef CNN_READER_TIMEOUT_EN
         wait_cnt_q <= '0;
         terr_q     <= 1'b0;
`endif
      end else begin
         start_q  <= 1'b0;
         cvalid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req) begin
                  state_q <= START;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
`ifdef CNN_READER_TIMEOUT_EN
                  terr_q  <= 1'b0;
`endif
               end
            end
            START: begin
               state_q <= WAIT;
`ifdef CNN_READER_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
            end
            WAIT: begin
               if (cnn_done) begin
                  for (int unsigned i = 0; i < FC_OUTPUTS; i++) buf_q[i] <= cnn_result[i];
                  ptr_q   <= '0;
                  valid_q <= 1'b1;
                  last_q  <= (FC_OUTPUTS == 1);
                  state_q <= STREAM;
               end
`ifdef CNN_READER_TIMEOUT_EN
               else if (wait_cnt_q == WCNT_W'(TIMEOUT_CYCLES - 1)) begin
                  terr_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
`endif
            end
            STREAM: begin
               // Pointer stops at the last index so the buffer read mux never goes out of range.
               if (accept) begin
                  if (ptr_q == LAST_IDX) begin
                     valid_q  <= 1'b0;
                     last_q   <= 1'b0;
                     cvalid_q <= 1'b1;
                     state_q  <= REPORT;
                  end else begin
                     ptr_q  <= ptr_q + 1'b1;
                     last_q <= (ptr_q + 1'b1 == LAST_IDX);
                  end
               end
            end
            REPORT: begin
               cidx_q  <= trk_idx;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy                = busy_q;
   assign cnn_start           = start_q;
   assign out_if.out_valid    = valid_q;
   assign out_if.out_last     = last_q;
   assign out_if.out_data     = buf_q[ptr_q];
   assign out_if.out_index    = ptr_q;
   assign out_if.class_valid  = cvalid_q;
   // Tracker absorbs the final beat on the REPORT entry edge, so REPORT shows it directly.
   assign out_if.class_idx    = cvalid_q ? trk_idx : cidx_q;

endmodule

// File: doc/cnn_result_reader.md
# cnn_result_reader

Host-side sequencer for the CNN pipeline top. On a host request it issues a one-cycle `start` pulse, waits for the pipeline's `done` pulse, captures the FC output vector, and streams it out one element per valid/ready beat. While streaming it tracks the signed argmax and reports the winning class index at the end. It sits between the host/testbench fabric and the CNN top.

## Interface
- `FC_OUTPUTS`, default 2: number of FC result elements (≥1).
- `DATA_WIDTH`, default 16: signed element width.
- `TIMEOUT_CYCLES`, default 4096: wait-state watchdog limit (≥1).
- `IDX_W`, default `$clog2(FC_OUTPUTS)` (minimum 1): index width.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: host request to run one inference. Sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `cnn_start` out 1: registered one-cycle start pulse to the CNN top.
- `cnn_done` in 1: one-cycle completion pulse from the CNN top.
- `cnn_result` in `[0:FC_OUTPUTS-1]` × `DATA_WIDTH` signed: CNN final outputs. Valid in the `cnn_done` cycle.
- `out_data` out `DATA_WIDTH` signed: streamed element.
- `out_index` out `IDX_W`: index of `out_data`.
- `out_valid` out 1, `out_ready` in 1: stream handshake.
- `out_last` out 1: high with the element at index `FC_OUTPUTS-1`.
- `class_idx` out `IDX_W`: argmax result.
- `class_valid` out 1: one-cycle pulse that qualifies `class_idx`.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- States: IDLE → START → WAIT → STREAM → REPORT → IDLE. WAIT can also exit to IDLE on timeout.
- IDLE: if `req`=1, go to START and clear `timeout_err`. `req` is ignored in every other state.
- START: `cnn_start`=1 for this one cycle, then WAIT.
- WAIT:
  - Count cycles with `wait_cnt`.
  - If `cnn_done`=1: latch all `cnn_result` into the capture buffer, clear the argmax tracker, set the element pointer to 0, go to STREAM.
  - `cnn_done` arriving in any state other than WAIT is ignored.
- STREAM:
  - `out_valid`=1; `out_data` = buffer[ptr]; `out_index` = ptr.
  - Outputs hold stable while `out_ready`=0.
  - On each accepted beat (`out_valid`&`out_ready`): update argmax, then increment ptr.
  - The accepted beat with ptr = `FC_OUTPUTS-1` moves to REPORT.
- Argmax rules:
  - Signed comparison.
  - The first element initialises the maximum.
  - A later element replaces the maximum only if strictly greater, so ties resolve to the lowest index.
- REPORT: `class_valid`=1 for one cycle with the final `class_idx`, then IDLE.
- `class_idx` holds its value until the next REPORT.
- Capture buffer and `class_idx` are not cleared when leaving REPORT.

## Timing
- Reset values:
  - State = IDLE.
  - `busy`, `cnn_start`, `out_valid`, `out_last`, `class_valid`, `timeout_err` = 0.
  - `out_data`, `out_index`, `class_idx` = 0.
  - Capture buffer and counters = 0.
- Reset asserted mid-operation aborts immediately: no further `cnn_start`, beats, or `class_valid`.
- Cycle timeline:
  - `req` sampled at edge N; `cnn_start` high during cycle N+1.
  - `cnn_done` sampled at edge M; first `out_valid` in cycle M+1.
  - With `out_ready` held high, `FC_OUTPUTS` beats take consecutive cycles.
  - `class_valid` asserts the cycle after the last accepted beat.
  - `busy` drops the cycle after REPORT.
- Minimum request-to-`class_valid` latency with an immediate `cnn_done` and `out_ready`=1: 3 + `FC_OUTPUTS` cycles.
- `cnn_done` arriving in the same cycle as the timeout expiry takes priority: capture proceeds and no error is raised.

## Configuration
- Macro `CNN_READER_TIMEOUT_EN`.
- Defined: `wait_cnt` is compared against `TIMEOUT_CYCLES`. On reaching the limit without `cnn_done`:
  - `timeout_err` is set (sticky until the next accepted `req` or reset).
  - State returns to IDLE.
  - No stream beats and no `class_valid` are produced.
- Undefined:
  - WAIT holds indefinitely.
  - `timeout_err` is constant 0.
  - No counter logic is synthesised.

## Structure
- Shared package `cnn_pkg`:
  - `DATA_WIDTH` default constant.
  - Typedef `cnn_data_t` (signed `DATA_WIDTH`).
  - State enum `reader_state_e` (IDLE, START, WAIT, STREAM, REPORT).
- One sub-module, `cnn_argmax_tracker`:
  - Inputs: `clk`, `reset`, clear, update strobe, data, index.
  - Outputs: max value, max index.
  - Reused by other classification paths.

## Test plan
- `FC_OUTPUTS`=2, `req` pulse, `cnn_done` 5 cycles after `cnn_start`, `cnn_result`={-3, 7}, `out_ready`=1 → beats (0,-3) then (1,7, `out_last`); `class_idx`=1 with `class_valid` one cycle later.
- `cnn_result`={4, 4} → `class_idx`=0 (tie resolves to lowest index).
- `out_ready` low for 3 cycles during beat 0 with result {9, -1} → `out_data`=9 and `out_index`=0 held stable; `class_idx`=0.
- With the macro defined and `TIMEOUT_CYCLES`=8, never assert `cnn_done` → `timeout_err`=1 after 8 WAIT cycles; no `out_valid`; next `req` clears `timeout_err`.
- `reset` asserted during STREAM after beat 0 → next cycle all outputs at reset values; no `class_valid`.
- `req` and stray `cnn_done` while in STREAM → both ignored; stream completes normally.
